// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Serial byte-stream loader for an instruction memory.
//                Collects bytes little-endian into 32-bit words and writes
//                DEPTH consecutive words starting at index 0. The CPU is
//                held in reset (busy) for the whole session.
//                Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//                (when defined, checksum accumulates every written word).
//  Revision    : 1.0  - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        ImemWrEn,
    output logic [31:0] ImemWrAddr,
    output logic [31:0] ImemWrData,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    // Word counter wide enough to hold the highest legal index DEPTH-1.
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] c_last_idx = CW'(DEPTH - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_recv  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_lane;
    logic [23:0]   r_asm;
    logic          r_wr_en;
    logic [31:0]   r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_busy;
    logic          r_done;
    logic          w_idle_like;
    logic          w_xfer;

    assign w_idle_like = (r_state == c_st_idle) || (r_state == c_st_done);

    // Ready is the only combinational output: an abort blocks the byte that
    // arrives in the same cycle, so a partial word can never complete then.
    assign byte_ready = (r_state == c_st_recv) && !abort;
    assign w_xfer     = byte_valid && byte_ready;

    // Next-state decision for the load session.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_next = c_st_recv;
                end
            end
            c_st_recv: begin
                if (abort) begin
                    w_state_next = c_st_idle;
                end else if (w_xfer && (r_lane == 2'd3)) begin
                    w_state_next = c_st_write;
                end
            end
            c_st_write: begin
                if (abort) begin
                    w_state_next = c_st_idle;
                end else if (r_cnt == c_last_idx) begin
                    w_state_next = c_st_done;
                end else begin
                    w_state_next = c_st_recv;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Status flags and write strobe are registered from the next state so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wr_en <= (w_state_next == c_st_write);
            r_busy  <= (w_state_next == c_st_recv) || (w_state_next == c_st_write);
            r_done  <= (w_state_next == c_st_done);
        end
    end

    // Byte assembly, word counter and the held write address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_lane    <= 2'd0;
            r_asm     <= 24'd0;
            r_wr_addr <= 32'd0;
            r_wr_data <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_cnt  <= '0;
                        r_lane <= 2'd0;
                        r_asm  <= 24'd0;
                    end
                end
                c_st_recv: begin
                    if (abort) begin
                        r_lane <= 2'd0;
                        r_asm  <= 24'd0;
                    end else if (w_xfer) begin
                        case (r_lane)
                            2'd0: r_asm[7:0]   <= byte_in;
                            2'd1: r_asm[15:8]  <= byte_in;
                            2'd2: r_asm[23:16] <= byte_in;
                            default: begin
                                // Fourth byte goes straight into the write
                                // data so the strobe follows the handshake.
                                r_wr_data <= {byte_in, r_asm};
                                r_wr_addr <= {{(32 - CW){1'b0}}, r_cnt};
                            end
                        endcase
                        r_lane <= r_lane + 2'd1;
                    end
                end
                c_st_write: begin
                    r_cnt  <= r_cnt + c_cnt_one;
                    r_lane <= 2'd0;
                end
                default: begin
                    r_lane <= 2'd0;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_csum;

    // Accumulate each word as its write cycle completes, so the sum is
    // final on the same edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= 32'd0;
        end else if (w_idle_like && start) begin
            r_csum <= 32'd0;
        end else if (r_state == c_st_write) begin
            r_csum <= r_csum + r_wr_data;
        end
    end

    assign checksum = r_csum;
`else
    assign checksum = 32'd0;
`endif

    assign ImemWrEn   = r_wr_en;
    assign ImemWrAddr = r_wr_addr;
    assign ImemWrData = r_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire
